// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings ({cs_n,ras_n,cas_n,we_n}) and arbiter state type.
package sdram_pkg;

  localparam logic [3:0]  CMD_NOP         = 4'b0111;
  localparam logic [3:0]  CMD_PRECHARGE   = 4'b0010;
  localparam logic [3:0]  CMD_AUTOREFRESH = 4'b0001;
  localparam logic [3:0]  CMD_ACTIVE      = 4'b0011;
  localparam logic [3:0]  CMD_READ        = 4'b0101;
  localparam logic [3:0]  CMD_WRITE       = 4'b0100;
  localparam logic [3:0]  CMD_MRS         = 4'b0000;

  localparam logic [1:0]  BA_IDLE   = 2'b11;
  localparam logic [11:0] ADDR_IDLE = 12'hfff;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ARBIT = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: fixed-priority grant of refresh/write/read after init,
// with the command bus muxed combinationally from the registered state.
//
// state     | meaning
// ARB_IDLE  | init sequence owns the bus
// ARB_ARBIT | NOP on bus, choose aref > write > read
// ARB_AREF  | refresh owns the bus until aref_end
// ARB_WRITE | write owns the bus until wr_end
// ARB_READ  | read owns the bus until rd_end
module sdram_arbit
  import sdram_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr
);

  arb_state_t  state_q, state_d;
  logic        aref_en_q, wr_en_q, rd_en_q, cke_q;
  logic        grant_ok;
  logic [3:0]  cmd;

  // init_end falling anywhere past idle throws the arbiter back to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (init_end) state_d = ARB_ARBIT;
      ARB_ARBIT: begin
        if (!init_end)     state_d = ARB_IDLE;
        else if (aref_req) state_d = ARB_AREF;
        else if (wr_req)   state_d = ARB_WRITE;
        else if (rd_req)   state_d = ARB_READ;
      end
      ARB_AREF:  if (!init_end) state_d = ARB_IDLE; else if (aref_end) state_d = ARB_ARBIT;
      ARB_WRITE: if (!init_end) state_d = ARB_IDLE; else if (wr_end)   state_d = ARB_ARBIT;
      ARB_READ:  if (!init_end) state_d = ARB_IDLE; else if (rd_end)   state_d = ARB_ARBIT;
      default:   state_d = ARB_IDLE;
    endcase
  end

  assign grant_ok = (state_q == ARB_ARBIT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ARB_IDLE;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      aref_en_q <= grant_ok && (state_d == ARB_AREF);
      wr_en_q   <= grant_ok && (state_d == ARB_WRITE);
      rd_en_q   <= grant_ok && (state_d == ARB_READ);
    end
  end

  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = BA_IDLE;
    sdram_addr = ADDR_IDLE;
    case (state_q)
      ARB_IDLE:  begin cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      ARB_AREF:  begin cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
      ARB_WRITE: begin cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      ARB_READ:  begin cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default:   ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = cke_q;

endmodule
